// File: rtl/mux_adc_sequencer.sv
// Steps the analog mux, waits for settling, then clocks one sample out of a serial ADC.
// Scan period: SW_HIGH + SW_LOW + SETTLE_CYCLES + 2*ADC_BITS*SCLK_DIV + 1 clk cycles.
// No backpressure: the sample_valid_o pulse is fire-and-forget, and the consumer must take it in that cycle.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   enable_i               level: 1 = scan continuously, 0 = stop after the current conversion
//   cnt_channel_i          channel counter from the mux switcher
//   mux_a3_i               third-mux address from the mux switcher
//   adc_sdo_i              serial data from the ADC
//   switch_signal_o        step strobe to the mux switcher
//   adc_cs_n_o             ADC chip select, active low
//   adc_sclk_o             ADC serial clock, idles low
//   sample_data_o          last converted sample
//   sample_channel_o       {mux_a3, cnt_channel} tag of the last sample
//   sample_valid_o         one-cycle pulse when sample_data_o/sample_channel_o update
//   busy_o                 high whenever the sequencer is not idle
module mux_adc_sequencer #(
    parameter int unsigned SW_HIGH       = 3,
    parameter int unsigned SW_LOW        = 2,
    parameter int unsigned SETTLE_CYCLES = 50,
    parameter int unsigned SCLK_DIV      = 4,
    parameter int unsigned ADC_BITS      = 12
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                enable_i,
    input  logic [4:0]          cnt_channel_i,
    input  logic [2:0]          mux_a3_i,
    input  logic                adc_sdo_i,
    output logic                switch_signal_o,
    output logic                adc_cs_n_o,
    output logic                adc_sclk_o,
    output logic [ADC_BITS-1:0] sample_data_o,
    output logic [7:0]          sample_channel_o,
    output logic                sample_valid_o,
    output logic                busy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STROBE,
        S_GAP,
        S_SETTLE,
        S_CONVERT,
        S_DONE
    } state_e;

    // Terminal counts, sized to the counters that are compared against them.
    localparam logic [15:0] STROBE_LAST = 16'(SW_HIGH - 1);
    localparam logic [15:0] GAP_LAST    = 16'(SW_LOW - 1);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [7:0]  DIV_LAST    = 8'(SCLK_DIV - 1);
    localparam logic [4:0]  BITS_END    = 5'(ADC_BITS);

    state_e              state_q;
    // One 16-bit phase counter serves STROBE, GAP and SETTLE; it is cleared on every
    // state exit, so it never wraps inside a state.
    logic [15:0]         cnt_q;
    logic [7:0]          div_q;      // clk cycles elapsed in the current sclk half-period
    logic [4:0]          bit_q;      // sclk rising edges issued in this conversion
    logic [ADC_BITS-1:0] shift_q;
    logic [7:0]          tag_q;      // mux address captured at the end of settling
    logic                switch_q;
    logic                cs_n_q;
    logic                sclk_q;
    logic [ADC_BITS-1:0] data_q;
    logic [7:0]          chan_q;
    logic                valid_q;
    logic                busy_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            div_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tag_q    <= '0;
            switch_q <= 1'b0;
            cs_n_q   <= 1'b1;
            sclk_q   <= 1'b0;
            data_q   <= '0;
            chan_q   <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            // The valid pulse is raised on entry to DONE and dropped on the next edge.
            valid_q <= 1'b0;

            unique case (state_q)
                S_IDLE: begin
                    if (enable_i) begin
                        state_q  <= S_STROBE;
                        switch_q <= 1'b1;
                        busy_q   <= 1'b1;
                        cnt_q    <= '0;
                    end
                end

                S_STROBE: begin
                    if (cnt_q == STROBE_LAST) begin
                        state_q  <= S_GAP;
                        switch_q <= 1'b0;
                        cnt_q    <= '0;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end

                S_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        state_q <= S_SETTLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end

                S_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        // The switcher's address is stable by now; this is the channel
                        // the conversion actually measures.
                        tag_q   <= {mux_a3_i, cnt_channel_i};
                        state_q <= S_CONVERT;
                        cnt_q   <= '0;
                        cs_n_q  <= 1'b0;
                        sclk_q  <= 1'b0;
                        div_q   <= '0;
                        bit_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end

                S_CONVERT: begin
                    if (div_q == DIV_LAST) begin
                        div_q <= '0;
                        if (!sclk_q) begin
                            // Rising sclk: capture the bit the ADC has been presenting
                            // for the whole low half-period.
                            sclk_q  <= 1'b1;
                            shift_q <= {shift_q[ADC_BITS-2:0], adc_sdo_i};
                            bit_q   <= bit_q + 5'd1;
                        end else if (bit_q == BITS_END) begin
                            // Last high half-period done: release the ADC.
                            sclk_q  <= 1'b0;
                            cs_n_q  <= 1'b1;
                            bit_q   <= '0;
                            state_q <= S_DONE;
                            data_q  <= shift_q;
                            chan_q  <= tag_q;
                            valid_q <= 1'b1;
                        end else begin
                            sclk_q <= 1'b0;
                        end
                    end else begin
                        div_q <= div_q + 8'd1;
                    end
                end

                S_DONE: begin
                    if (enable_i) begin
                        state_q  <= S_STROBE;
                        switch_q <= 1'b1;
                        cnt_q    <= '0;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign switch_signal_o  = switch_q;
    assign adc_cs_n_o       = cs_n_q;
    assign adc_sclk_o       = sclk_q;
    assign sample_data_o    = data_q;
    assign sample_channel_o = chan_q;
    assign sample_valid_o   = valid_q;
    assign busy_o           = busy_q;

endmodule

// File: tb/tb_mux_adc_sequencer.sv
// Bench for mux_adc_sequencer: two instances with different parameter sets.
// Latency/backpressure: n/a (testbench).
// Every cycle both instances are compared against an offset-within-scan model.
module tb_mux_adc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  en;
    logic [1:0]  sdo;
    logic [4:0]  cnt;
    logic [2:0]  mux;
    logic [1:0]  sw, csn, sclk, vld, busy;
    logic [11:0] data_a;
    logic [15:0] data_b;
    logic [7:0]  ch_a, ch_b;

    always #5 clk = ~clk;

    mux_adc_sequencer #(.SW_HIGH(3), .SW_LOW(2), .SETTLE_CYCLES(4), .SCLK_DIV(2), .ADC_BITS(12)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(en[0]), .cnt_channel_i(cnt), .mux_a3_i(mux),
        .adc_sdo_i(sdo[0]), .switch_signal_o(sw[0]), .adc_cs_n_o(csn[0]), .adc_sclk_o(sclk[0]),
        .sample_data_o(data_a), .sample_channel_o(ch_a), .sample_valid_o(vld[0]), .busy_o(busy[0]));

    mux_adc_sequencer #(.SW_HIGH(3), .SW_LOW(2), .SETTLE_CYCLES(1), .SCLK_DIV(1), .ADC_BITS(16)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(en[1]), .cnt_channel_i(cnt), .mux_a3_i(mux),
        .adc_sdo_i(sdo[1]), .switch_signal_o(sw[1]), .adc_cs_n_o(csn[1]), .adc_sclk_o(sclk[1]),
        .sample_data_o(data_b), .sample_channel_o(ch_b), .sample_valid_o(vld[1]), .busy_o(busy[1]));

    int tests = 0;
    int fails = 0;

    // Parameters of each instance as seen by the model.
    int settle_p[2] = '{4, 1};
    int div_p[2]    = '{2, 1};
    int bits_p[2]   = '{12, 16};

    // Model: o = cycle offset inside the current scan (0 = first strobe cycle), -1 = idle.
    int          o[2];
    logic [15:0] word[2];
    logic [15:0] exp_data[2];
    logic [7:0]  tag[2];
    logic [7:0]  exp_ch[2];
    bit          rand_word[2];
    // ADC responder state: rising edges seen in this chip-select window.
    int          rc[2];
    logic        prev_sclk[2];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            o[i]         = -1;
            exp_data[i]  = '0;
            exp_ch[i]    = '0;
            tag[i]       = '0;
            rc[i]        = 0;
            prev_sclk[i] = 1'b0;
        end
    endtask

    task automatic model_step();
        int c0, n, p;
        logic [31:0] m;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                o[i] = -1; exp_data[i] = '0; exp_ch[i] = '0;
            end else begin
                c0 = 5 + settle_p[i];
                n  = 2 * bits_p[i] * div_p[i];
                p  = c0 + n + 1;
                if (o[i] == c0 - 1) tag[i] = {mux, cnt};
                if (o[i] < 0 || o[i] == p - 1) o[i] = en[i] ? 0 : -1;
                else o[i] = o[i] + 1;
                if (o[i] == 0 && rand_word[i]) word[i] = 16'($urandom);
                if (o[i] == p - 1) begin
                    m = (32'd1 << bits_p[i]) - 32'd1;
                    exp_data[i] = word[i] & m[15:0];
                    exp_ch[i]   = tag[i];
                end
            end
        end
    endtask

    function automatic logic [28:0] exp_vec(int i);
        int c0, n, p, oo;
        logic s, cs, sk, v, b;
        c0 = 5 + settle_p[i];
        n  = 2 * bits_p[i] * div_p[i];
        p  = c0 + n + 1;
        oo = o[i];
        s  = (oo >= 0) && (oo < 3);
        cs = !((oo >= c0) && (oo < c0 + n));
        sk = 1'b0;
        if (!cs) sk = (((oo - c0) / div_p[i]) % 2) == 1;
        v  = (oo == p - 1);
        b  = (oo >= 0);
        return {s, cs, sk, v, b, exp_data[i], exp_ch[i]};
    endfunction

    task automatic check_all();
        logic [28:0] act;
        act = {sw[0], csn[0], sclk[0], vld[0], busy[0], 4'h0, data_a, ch_a};
        chk("cycle_a", 32'(act), 32'(exp_vec(0)));
        act = {sw[1], csn[1], sclk[1], vld[1], busy[1], data_b, ch_b};
        chk("cycle_b", 32'(act), 32'(exp_vec(1)));
    endtask

    // Serial ADC: presents the MSB while chip select is low and advances one bit
    // after every sclk rising edge it observes.
    task automatic adc_step();
        int idx;
        for (int i = 0; i < 2; i++) begin
            if (csn[i]) rc[i] = 0;
            else if (sclk[i] && !prev_sclk[i]) rc[i] = rc[i] + 1;
            prev_sclk[i] = sclk[i];
            sdo[i] = 1'b0;
            if (rc[i] < bits_p[i]) begin
                idx = bits_p[i] - 1 - rc[i];
                sdo[i] = word[i][idx];
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
        adc_step();
    endtask

    typedef struct {
        int          n;
        logic        en;
        logic        sw, csn, sclk, vld, bsy;
        logic [11:0] data;
        logic [7:0]  ch;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int sw_hi, cs_lo, rises, nv, lo;
        logic sk_prev;
        bit got;

        // Single conversion on instance A, starting from idle.
        tbl[0] = '{1,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 12'h000, 8'h00};
        tbl[1] = '{2,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 12'h000, 8'h00};
        tbl[2] = '{1,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 12'h000, 8'h00};
        tbl[3] = '{5,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 12'h000, 8'h00};
        tbl[4] = '{1,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000, 8'h00};
        tbl[5] = '{2,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 12'h000, 8'h00};
        tbl[6] = '{45,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 12'h000, 8'h00};
        tbl[7] = '{1,   1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 12'hA5C, 8'h29};
        tbl[8] = '{1,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'hA5C, 8'h29};
        tbl[9] = '{100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'hA5C, 8'h29};

        rst_n = 1'b0; en = '0; sdo = '0; cnt = '0; mux = '0;
        rand_word[0] = 1'b1; rand_word[1] = 1'b1;
        word[0] = '0; word[1] = '0;
        model_reset();

        // Reset held with random inputs.
        for (int k = 0; k < 8; k++) begin
            en = 2'($urandom); cnt = 5'($urandom); mux = 3'($urandom); sdo = 2'($urandom);
            tick();
        end
        rst_n = 1'b1; en = '0;
        for (int k = 0; k < 100; k++) tick();

        // Table-driven single conversion.
        rand_word[0] = 1'b0; word[0] = 16'h0A5C; cnt = 5'd9; mux = 3'd1;
        sw_hi = 0; cs_lo = 0; rises = 0; sk_prev = 1'b0;
        for (int v = 0; v < 10; v++) begin
            en[0] = tbl[v].en;
            for (int k = 0; k < tbl[v].n; k++) begin
                tick();
                if (sw[0]) sw_hi++;
                if (!csn[0]) cs_lo++;
                if (sclk[0] && !sk_prev) rises++;
                sk_prev = sclk[0];
            end
            chk($sformatf("tbl%0d_sw", v),   32'(sw[0]),   32'(tbl[v].sw));
            chk($sformatf("tbl%0d_csn", v),  32'(csn[0]),  32'(tbl[v].csn));
            chk($sformatf("tbl%0d_sclk", v), 32'(sclk[0]), 32'(tbl[v].sclk));
            chk($sformatf("tbl%0d_vld", v),  32'(vld[0]),  32'(tbl[v].vld));
            chk($sformatf("tbl%0d_busy", v), 32'(busy[0]), 32'(tbl[v].bsy));
            chk($sformatf("tbl%0d_data", v), 32'(data_a),  32'(tbl[v].data));
            chk($sformatf("tbl%0d_ch", v),   32'(ch_a),    32'(tbl[v].ch));
        end
        chk("single_sw_high_cycles", 32'(sw_hi), 32'd3);
        chk("single_cs_low_cycles", 32'(cs_lo), 32'd48);
        chk("single_sclk_rises", 32'(rises), 32'd12);

        // Enable dropped during the conversion, after the fifth bit.
        rand_word[0] = 1'b1;
        en[0] = 1'b1;
        for (int k = 0; k < 300 && rc[0] < 5; k++) tick();
        chk("drop_reached_bit5", 32'(rc[0] >= 5), 32'd1);
        en[0] = 1'b0;
        nv = 0;
        for (int k = 0; k < 120; k++) begin
            tick();
            if (vld[0]) nv++;
        end
        chk("drop_valid_count", 32'(nv), 32'd1);
        chk("drop_idle", 32'({busy[0], csn[0], sclk[0]}), 32'b010);

        // Reset asserted during the conversion, after the seventh bit.
        en[0] = 1'b1;
        for (int k = 0; k < 300 && rc[0] < 7; k++) tick();
        chk("rst_reached_bit7", 32'(rc[0] >= 7), 32'd1);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_async_csn", 32'(csn[0]), 32'd1);
        chk("rst_async_sclk", 32'(sclk[0]), 32'd0);
        chk("rst_async_vld", 32'(vld[0]), 32'd0);
        check_all();
        for (int k = 0; k < 3; k++) begin
            cnt = 5'($urandom); mux = 3'($urandom);
            tick();
        end
        rst_n = 1'b1;
        nv = 0;
        for (int k = 0; k < 70; k++) begin
            tick();
            if (vld[0]) nv++;
        end
        chk("rst_recover_valid_count", 32'(nv), 32'd1);
        en[0] = 1'b0;
        for (int k = 0; k < 70; k++) tick();

        // Boundary instance: fastest sclk, shortest settle, widest word.
        rand_word[1] = 1'b0; word[1] = 16'hFFFF;
        en[1] = 1'b1;
        for (int s = 0; s < 2; s++) begin
            lo = 0; got = 1'b0;
            for (int k = 0; k < 100 && !got; k++) begin
                tick();
                if (!csn[1]) lo++;
                if (vld[1]) got = 1'b1;
            end
            chk($sformatf("bnd%0d_done", s), 32'(got), 32'd1);
            chk($sformatf("bnd%0d_data", s), 32'(data_b), (s == 0) ? 32'h0000FFFF : 32'h00000001);
            chk($sformatf("bnd%0d_cs_len", s), 32'(lo), 32'd32);
            word[1] = 16'h0001;
        end
        en[1] = 1'b0;
        for (int k = 0; k < 50; k++) tick();

        // Randomized scanning: slow enable bursts, then per-cycle enable noise.
        rand_word[0] = 1'b1; rand_word[1] = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < 2; i++) if ($urandom_range(39, 0) == 0) en[i] = ~en[i];
            cnt = 5'($urandom); mux = 3'($urandom);
            tick();
        end
        for (int k = 0; k < 600; k++) begin
            en = 2'($urandom); cnt = 5'($urandom); mux = 3'($urandom);
            tick();
        end
        en = '0;
        for (int k = 0; k < 80; k++) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
